subtractor_bitserial: RTL

Bit-serial, multi-cycle subtractor that computes A - B one bit per clock, LSB first.
It sits beside the combinational n-bit ripple subtractor in the pimsynth submodule set and consumes the same 1-bit subtractor cell. It is the area-minimal option for PIM mappings, trading WIDTH cycles of latency for a single full-subtractor instance.
It has a valid/ready handshake on both input and output so it can sit between operand-staging and result-writeback stages.

---
 rtl/subtractor_bitserial_pkg.sv | 16 +
 rtl/subtractor_bitserial_cell.sv | 30 +++
 rtl/subtractor_bitserial.sv | 121 ++++++++++++
 3 files changed

// File: rtl/subtractor_bitserial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package subtractor_bitserial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be at least one bit wide, even when WIDTH == 1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/subtractor_bitserial_cell.sv
// 1-bit full subtractor cell (Sub = A - B - Bin).
// IMPL_TYPE selects the gate-level structure.
module subtractor_1bit #(
    parameter int IMPL_TYPE = 0
) (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Sub,
    output logic Bout
);

    generate
        if (IMPL_TYPE == 0) begin : g_sop
            assign Sub  = A ^ B ^ Bin;
            assign Bout = (~A & B) | (~A & Bin) | (B & Bin);
        end else begin : g_half
            // Two cascaded half-subtractors.
            logic w_d1;
            logic w_b1;
            logic w_b2;
            assign w_d1 = A ^ B;
            assign w_b1 = ~A & B;
            assign Sub  = w_d1 ^ Bin;
            assign w_b2 = ~w_d1 & Bin;
            assign Bout = w_b1 | w_b2;
        end
    endgenerate

endmodule

// File: rtl/subtractor_bitserial.sv
// Bit-serial subtractor: A - B, one bit per clock LSB first, valid/ready on both sides.
// Define SUBTRACTOR_BITSERIAL_PIPE_EN to allow accepting a new operand pair on result handoff.
module subtractor_bitserial
    import subtractor_bitserial_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int          IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sub,
    output logic             Bout
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sub;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_bout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_sub;
    logic             w_bout;
    logic             w_last;

    subtractor_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_cell (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Bin  (r_borrow),
        .Sub  (w_sub),
        .Bout (w_bout)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef SUBTRACTOR_BITSERIAL_PIPE_EN
    assign in_ready = r_in_ready | ((r_state == DONE) & out_ready);
`else
    assign in_ready = r_in_ready;
`endif
    assign out_valid = r_out_valid;
    assign Sub       = r_sub;
    assign Bout      = r_bout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= '0;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_bout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= A;
                        r_b        <= B;
                        r_borrow   <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    r_sub    <= (r_sub >> 1) | (WIDTH'(w_sub) << (WIDTH - 1));
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_bout;
                    if (w_last) begin
                        r_bout      <= w_bout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
`ifdef SUBTRACTOR_BITSERIAL_PIPE_EN
                        if (in_valid) begin
                            r_a      <= A;
                            r_b      <= B;
                            r_borrow <= 1'b0;
                            r_cnt    <= '0;
                            r_state  <= RUN;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= IDLE;
                        end
`else
                        r_in_ready <= 1'b1;
                        r_state    <= IDLE;
`endif
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule
